// File: rtl/btn_event_pkg.sv
// Shared definitions for the button click classifier: channel state encoding
// and default timing constants (in 1 ms ticks).
package btn_event_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESSED = 3'd1,
    LHELD   = 3'd2,
    WAIT2   = 3'd3,
    PRESS2  = 3'd4
  } state_t;

  localparam int DEF_LONG_MS = 1000;
  localparam int DEF_DBL_MS  = 300;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_ch.sv
// One button channel: edge detector, click-classification FSM and tick counter.
// Event outputs are registered one-clock pulses.
module btn_event_ch
  import btn_event_pkg::*;
#(
  parameter int LONG_MS = DEF_LONG_MS,
  parameter int DBL_MS  = DEF_DBL_MS
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   tick,
  input  logic   btn,
  output logic   short_press,
  output logic   long_press,
  output logic   dbl_click,
  output state_t state_dbg
);

  localparam int MAX_MS = max_int(LONG_MS, DBL_MS);
  localparam int CW     = $clog2(MAX_MS);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_MS - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          prev;
  logic          rise, fall;
  logic          short_n, long_n, dbl_n;

  assign rise      = btn & ~prev;
  assign fall      = ~btn & prev;
  assign state_dbg = state;

  // prev resets high so a button held through reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      prev        <= 1'b1;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      dbl_click   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      prev        <= btn;
      short_press <= short_n;
      long_press  <= long_n;
      dbl_click   <= dbl_n;
    end
  end

  // Edges are tested before timeouts so an edge wins a same-cycle collision.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    short_n = 1'b0;
    long_n  = 1'b0;
    dbl_n   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_n = WAIT2;
          cnt_n   = '0;
        end else if (tick) begin
          if (cnt == LONG_LAST) begin
            long_n  = 1'b1;
            state_n = LHELD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      LHELD: begin
        if (fall) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      WAIT2: begin
        if (rise) begin
          dbl_n   = 1'b1;
          state_n = PRESS2;
          cnt_n   = '0;
        end else if (tick) begin
          if (cnt == DBL_LAST) begin
            short_n = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      PRESS2: begin
        if (fall) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_event.sv
// Per-button click classifier: N independent channels turning debounced levels
// into short-press, long-press and double-click pulses.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int N       = 2,
  parameter int LONG_MS = DEF_LONG_MS,
  parameter int DBL_MS  = DEF_DBL_MS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [N-1:0]   btnDb,
  output logic [N-1:0]   shortPress,
  output logic [N-1:0]   longPress,
  output logic [N-1:0]   dblClick,
  output logic [3*N-1:0] dbg_state
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t st;

    btn_event_ch #(
      .LONG_MS (LONG_MS),
      .DBL_MS  (DBL_MS)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .btn         (btnDb[i]),
      .short_press (shortPress[i]),
      .long_press  (longPress[i]),
      .dbl_click   (dblClick[i]),
      .state_dbg   (st)
    );

    assign dbg_state[3*i +: 3] = st;
  end

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event: LONG_MS=20, DBL_MS=8, one tick every 10 clk.
module tb_btn_event;

  localparam int N = 2;

  logic           clk;
  logic           rst_n;
  logic           tick;
  logic [N-1:0]   btnDb;
  logic [N-1:0]   shortPress;
  logic [N-1:0]   longPress;
  logic [N-1:0]   dblClick;
  logic [3*N-1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  btn_event #(
    .N       (N),
    .LONG_MS (20),
    .DBL_MS  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .btnDb      (btnDb),
    .shortPress (shortPress),
    .longPress  (longPress),
    .dblClick   (dblClick),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock with given inputs; outputs are checked 1 ns after the edge.
  task automatic cycle(input logic [1:0] b, input logic t,
                       input logic [1:0] es, input logic [1:0] el, input logic [1:0] ed);
    btnDb = b;
    tick  = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
    check_eq("shortPress", 32'(shortPress), 32'(es));
    check_eq("longPress",  32'(longPress),  32'(el));
    check_eq("dblClick",   32'(dblClick),   32'(ed));
  endtask

  task automatic idle(input logic [1:0] b, input int n);
    for (int i = 0; i < n; i++) cycle(b, 1'b0, 2'b00, 2'b00, 2'b00);
  endtask

  // n ticks (9 quiet clk then a tick clk); expected pulses apply to the last tick only.
  task automatic ticks(input logic [1:0] b, input int n,
                       input logic [1:0] es, input logic [1:0] el, input logic [1:0] ed);
    for (int i = 0; i < n; i++) begin
      idle(b, 9);
      if (i == n - 1) cycle(b, 1'b1, es, el, ed);
      else            cycle(b, 1'b1, 2'b00, 2'b00, 2'b00);
    end
  endtask

  task automatic do_reset(input logic [1:0] b);
    rst_n = 1'b0;
    btnDb = b;
    tick  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_short", 32'(shortPress), 32'd0);
      check_eq("rst_long",  32'(longPress),  32'd0);
      check_eq("rst_dbl",   32'(dblClick),   32'd0);
      check_eq("rst_state", 32'(dbg_state),  32'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    btnDb = '0;
    do_reset(2'b00);
    idle(2'b00, 3);

    // 1: short press on btn0
    cycle(2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    check_eq("s1_pressed_state", 32'(dbg_state[2:0]), 32'd1);
    ticks(2'b01, 5, 2'b00, 2'b00, 2'b00);
    cycle(2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    check_eq("s1_wait2_state", 32'(dbg_state[2:0]), 32'd3);
    ticks(2'b00, 8, 2'b01, 2'b00, 2'b00);
    check_eq("s1_idle_state", 32'(dbg_state[2:0]), 32'd0);
    ticks(2'b00, 3, 2'b00, 2'b00, 2'b00);

    // 2: long press on btn1, release silent
    cycle(2'b10, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b10, 20, 2'b00, 2'b10, 2'b00);
    check_eq("s2_lheld_state", 32'(dbg_state[5:3]), 32'd2);
    ticks(2'b10, 10, 2'b00, 2'b00, 2'b00);
    cycle(2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b00, 10, 2'b00, 2'b00, 2'b00);

    // 3: double click on btn0
    cycle(2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b01, 3, 2'b00, 2'b00, 2'b00);
    cycle(2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b00, 4, 2'b00, 2'b00, 2'b00);
    cycle(2'b01, 1'b0, 2'b00, 2'b00, 2'b01);
    check_eq("s3_press2_state", 32'(dbg_state[2:0]), 32'd4);
    cycle(2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b01, 2, 2'b00, 2'b00, 2'b00);
    cycle(2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b00, 10, 2'b00, 2'b00, 2'b00);

    // 4a: release coincides with 20th tick -> short press, no long press
    cycle(2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b01, 19, 2'b00, 2'b00, 2'b00);
    idle(2'b01, 9);
    cycle(2'b00, 1'b1, 2'b00, 2'b00, 2'b00);
    ticks(2'b00, 8, 2'b01, 2'b00, 2'b00);
    ticks(2'b00, 2, 2'b00, 2'b00, 2'b00);

    // 4b: rise coincides with 8th WAIT2 tick -> double click, no short press
    cycle(2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b01, 2, 2'b00, 2'b00, 2'b00);
    cycle(2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b00, 7, 2'b00, 2'b00, 2'b00);
    idle(2'b00, 9);
    cycle(2'b01, 1'b1, 2'b00, 2'b00, 2'b01);
    ticks(2'b01, 1, 2'b00, 2'b00, 2'b00);
    cycle(2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b00, 10, 2'b00, 2'b00, 2'b00);

    // 5a: reset at tick 15 of a press aborts it
    cycle(2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b01, 15, 2'b00, 2'b00, 2'b00);
    do_reset(2'b00);
    ticks(2'b00, 25, 2'b00, 2'b00, 2'b00);

    // 5b: button held across reset release produces nothing
    do_reset(2'b01);
    ticks(2'b01, 30, 2'b00, 2'b00, 2'b00);
    check_eq("s5_held_state", 32'(dbg_state[2:0]), 32'd0);
    cycle(2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b00, 10, 2'b00, 2'b00, 2'b00);

    // 5c: fresh press after reset behaves normally
    cycle(2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b01, 1, 2'b00, 2'b00, 2'b00);
    cycle(2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b00, 8, 2'b01, 2'b00, 2'b00);
    ticks(2'b00, 2, 2'b00, 2'b00, 2'b00);

    // 6a: overlapping btn0 short and btn1 long, pulses on separate cycles
    cycle(2'b11, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b11, 5, 2'b00, 2'b00, 2'b00);
    cycle(2'b10, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b10, 8, 2'b01, 2'b00, 2'b00);
    ticks(2'b10, 7, 2'b00, 2'b10, 2'b00);
    cycle(2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b00, 3, 2'b00, 2'b00, 2'b00);

    // 6b: btn0 short and btn1 long pulse in the same clk
    cycle(2'b10, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b10, 7, 2'b00, 2'b00, 2'b00);
    cycle(2'b11, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b11, 5, 2'b00, 2'b00, 2'b00);
    cycle(2'b10, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b10, 8, 2'b01, 2'b10, 2'b00);
    cycle(2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    ticks(2'b00, 10, 2'b00, 2'b00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
